// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light phase interface: phase codes,
// default yellow window, transition legality and the 7-segment font.
package traffic_pkg;

  localparam logic [1:0] PH_OFF     = 2'd0;
  localparam logic [1:0] PH_LEFT    = 2'd1;
  localparam logic [1:0] PH_FORWARD = 2'd2;
  localparam logic [1:0] PH_RIGHT   = 2'd3;

  localparam int         YELLOW_T_DEF = 3;
  localparam logic [6:0] SEG_BLANK    = 7'h7F;

  typedef enum logic [1:0] {
    BCD_IDLE,
    BCD_LOAD,
    BCD_SHIFT,
    BCD_DONE
  } bcd_state_e;

  // The generator walks OFF -> FORWARD -> RIGHT -> LEFT and may drop to OFF at any time.
  function automatic logic phase_step_legal(input logic [1:0] prev_ph,
                                            input logic [1:0] next_ph);
    return (next_ph == prev_ph) ||
           (next_ph == PH_OFF) ||
           ((prev_ph == PH_OFF)     && (next_ph == PH_FORWARD)) ||
           ((prev_ph == PH_FORWARD) && (next_ph == PH_RIGHT)) ||
           ((prev_ph == PH_RIGHT)   && (next_ph == PH_LEFT));
  endfunction

  // Font is written active-high {g,f,e,d,c,b,a} and inverted for the common-anode display.
  function automatic logic [6:0] seg7_n(input logic [3:0] digit);
    logic [6:0] seg_on;
    case (digit)
      4'd0:    seg_on = 7'b0111111;
      4'd1:    seg_on = 7'b0000110;
      4'd2:    seg_on = 7'b1011011;
      4'd3:    seg_on = 7'b1001111;
      4'd4:    seg_on = 7'b1100110;
      4'd5:    seg_on = 7'b1101101;
      4'd6:    seg_on = 7'b1111101;
      4'd7:    seg_on = 7'b0000111;
      4'd8:    seg_on = 7'b1111111;
      4'd9:    seg_on = 7'b1101111;
      default: seg_on = 7'b0000000;
    endcase
    return ~seg_on;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter for 0..99: one LOAD, seven SHIFT and one
// DONE cycle per conversion; results hold until the next DONE.
module bin2bcd_seq
  import traffic_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] bin,
  output logic       busy,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  bcd_state_e  state_q, state_d;
  logic [14:0] sh_q, sh_d;      // {tens, ones, binary}
  logic [2:0]  step_q, step_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;

  function automatic logic [14:0] dabble_step(input logic [14:0] sh);
    logic [14:0] t;
    t = sh;
    if (t[10:7]  >= 4'd5) t[10:7]  = t[10:7]  + 4'd3;
    if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
    return {t[13:0], 1'b0};
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    step_d  = step_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    case (state_q)
      BCD_IDLE: begin
        if (start) state_d = BCD_LOAD;
      end
      BCD_LOAD: begin
        sh_d    = {8'd0, bin};
        step_d  = 3'd0;
        state_d = BCD_SHIFT;
      end
      BCD_SHIFT: begin
        sh_d   = dabble_step(sh_q);
        step_d = step_q + 3'd1;
        if (step_q == 3'd6) state_d = BCD_DONE;
      end
      BCD_DONE: begin
        tens_d  = sh_q[14:11];
        ones_d  = sh_q[10:7];
        state_d = BCD_IDLE;
      end
      default: state_d = BCD_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BCD_IDLE;
      sh_q    <= '0;
      step_q  <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      step_q  <= step_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
    end
  end

  assign busy = (state_q != BCD_IDLE);
  assign done = (state_q == BCD_DONE);
  assign tens = tens_q;
  assign ones = ones_q;

endmodule

// File: rtl/phase_lamp_decoder.sv
// Decodes the {phase, countdown} interface into lamp drives, flags illegal
// phase steps, and shows the remaining seconds on a two-digit scanned display.
module phase_lamp_decoder
  import traffic_pkg::*;
#(
  parameter int YELLOW_T = YELLOW_T_DEF,
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       phase_in,
  input  logic [CNT_W-1:0] count_in,
  output logic             lamp_red,
  output logic             lamp_yellow,
  output logic [2:0]       lamp_green,
  output logic [6:0]       seg_n,
  output logic [1:0]       dig_n,
  output logic             disp_valid,
  output logic             seq_err
);

  localparam int SCAN_W = $clog2(SCAN_DIV);

  logic [1:0]       ph_q, ph_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       prev_ph_q, prev_ph_d;
  logic             seq_err_q, seq_err_d;
  logic             red_q, red_d;
  logic             yellow_q, yellow_d;
  logic [2:0]       green_q, green_d;
  logic [6:0]       last_bin_q, last_bin_d;
  logic             ran_q, ran_d;
  logic             load_q, load_d;
  logic             disp_valid_q, disp_valid_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic             dig_sel_q, dig_sel_d;   // 0 = ones, 1 = tens

  logic [6:0] disp_bin;
  logic       bcd_start, bcd_busy, bcd_done;
  logic [3:0] bcd_tens, bcd_ones;
  logic       scan_wrap;

  always_comb begin
    ph_d  = phase_in;
    cnt_d = count_in;

    red_d    = 1'b0;
    yellow_d = 1'b0;
    green_d  = 3'b000;
    if (ph_q == PH_OFF) begin
      red_d = 1'b1;
    end else if (cnt_q <= CNT_W'(YELLOW_T)) begin
      yellow_d = 1'b1;
    end else begin
      case (ph_q)
        PH_LEFT:    green_d = 3'b001;
        PH_FORWARD: green_d = 3'b010;
        default:    green_d = 3'b100;
      endcase
    end

    prev_ph_d = ph_q;
    seq_err_d = seq_err_q | ~phase_step_legal(prev_ph_q, ph_q);
  end

  // Display path: saturate, detect a new value, and remember what the converter took.
  always_comb begin
    disp_bin     = (cnt_q > CNT_W'(99)) ? 7'd99 : cnt_q[6:0];
    bcd_start    = ~ran_q | (disp_bin != last_bin_q);
    load_d       = bcd_start & ~bcd_busy;
    last_bin_d   = load_q ? disp_bin : last_bin_q;
    ran_d        = ran_q | load_q;
    disp_valid_d = disp_valid_q | bcd_done;

    scan_wrap = (scan_q == SCAN_W'(SCAN_DIV - 1));
    scan_d    = scan_wrap ? '0 : scan_q + 1'b1;
    dig_sel_d = dig_sel_q ^ scan_wrap;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ph_q         <= PH_OFF;
      cnt_q        <= '0;
      prev_ph_q    <= PH_OFF;
      seq_err_q    <= 1'b0;
      red_q        <= 1'b1;
      yellow_q     <= 1'b0;
      green_q      <= 3'b000;
      last_bin_q   <= '0;
      ran_q        <= 1'b0;
      load_q       <= 1'b0;
      disp_valid_q <= 1'b0;
      scan_q       <= '0;
      dig_sel_q    <= 1'b0;
    end else begin
      ph_q         <= ph_d;
      cnt_q        <= cnt_d;
      prev_ph_q    <= prev_ph_d;
      seq_err_q    <= seq_err_d;
      red_q        <= red_d;
      yellow_q     <= yellow_d;
      green_q      <= green_d;
      last_bin_q   <= last_bin_d;
      ran_q        <= ran_d;
      load_q       <= load_d;
      disp_valid_q <= disp_valid_d;
      scan_q       <= scan_d;
      dig_sel_q    <= dig_sel_d;
    end
  end

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (bcd_start),
    .bin   (disp_bin),
    .busy  (bcd_busy),
    .done  (bcd_done),
    .tens  (bcd_tens),
    .ones  (bcd_ones)
  );

  // Tens digit is blanked when zero so single-digit counts read naturally.
  always_comb begin
    seg_n = SEG_BLANK;
    if (disp_valid_q) begin
      if (!dig_sel_q)          seg_n = seg7_n(bcd_ones);
      else if (bcd_tens != 0)  seg_n = seg7_n(bcd_tens);
    end
  end

  assign dig_n       = dig_sel_q ? 2'b01 : 2'b10;
  assign lamp_red    = red_q;
  assign lamp_yellow = yellow_q;
  assign lamp_green  = green_q;
  assign disp_valid  = disp_valid_q;
  assign seq_err     = seq_err_q;

endmodule

// File: tb/tb_phase_lamp_decoder.sv
// Scoreboard bench for phase_lamp_decoder: lamp/seq_err expectations are queued
// as stimulus is driven and popped two clocks later; the display is modelled per cycle.
module tb_phase_lamp_decoder;

  localparam int         SCAN_DIV = 4;
  localparam logic [1:0] OFF = 2'd0, LEFT = 2'd1, FWD = 2'd2, RIGHT = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  phase_in = OFF;
  logic [31:0] count_in = '0;
  logic        lamp_red, lamp_yellow, disp_valid, seq_err;
  logic [2:0]  lamp_green;
  logic [6:0]  seg_n;
  logic [1:0]  dig_n;

  phase_lamp_decoder #(.YELLOW_T(3), .SCAN_DIV(SCAN_DIV), .CNT_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .phase_in    (phase_in),
    .count_in    (count_in),
    .lamp_red    (lamp_red),
    .lamp_yellow (lamp_yellow),
    .lamp_green  (lamp_green),
    .seg_n       (seg_n),
    .dig_n       (dig_n),
    .disp_valid  (disp_valid),
    .seq_err     (seq_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Model state
  logic [5:0] lamp_q[$];   // {red, yellow, green[2:0], seq_err}
  logic [1:0] m_prev;
  logic       m_err;
  int         k;           // clocks since reset release
  logic       disp_chk = 1'b0;
  logic       e_v = 1'b0;
  logic [3:0] e_t = '0, e_o = '0;

  function automatic logic legal(input logic [1:0] a, input logic [1:0] b);
    if (a == b || b == OFF) return 1'b1;
    return (a == OFF && b == FWD) || (a == FWD && b == RIGHT) || (a == RIGHT && b == LEFT);
  endfunction

  function automatic logic [5:0] lamp_model(input logic [1:0] p, input logic [31:0] c,
                                            input logic err);
    if (p == OFF) return {2'b10, 3'b000, err};
    if (c <= 32'd3) return {2'b01, 3'b000, err};
    case (p)
      LEFT:    return {2'b00, 3'b001, err};
      FWD:     return {2'b00, 3'b010, err};
      default: return {2'b00, 3'b100, err};
    endcase
  endfunction

  function automatic logic [6:0] seg_exp(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      default: return 7'h10;
    endcase
  endfunction

  task automatic tick(input logic [1:0] p, input logic [31:0] c);
    logic       tens_act;
    logic [6:0] s_exp;
    phase_in = p;
    count_in = c;
    if (!legal(m_prev, p)) m_err = 1'b1;
    m_prev = p;
    lamp_q.push_back(lamp_model(p, c, m_err));
    @(posedge clk);
    @(negedge clk);
    k++;
    if (lamp_q.size() >= 2) check("lamps", {lamp_red, lamp_yellow, lamp_green, seq_err}, lamp_q.pop_front());
    tens_act = ((k / SCAN_DIV) % 2) == 1;
    check("dig_n", dig_n, tens_act ? 2'b01 : 2'b10);
    if (disp_chk) begin
      if (!e_v || (tens_act && e_t == 4'd0)) s_exp = 7'h7F;
      else s_exp = seg_exp(tens_act ? e_t : e_o);
      check("disp_valid", disp_valid, e_v);
      if (tens_act) check("seg_tens", seg_n, s_exp);
      else          check("seg_ones", seg_n, s_exp);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    phase_in = OFF;
    count_in = '0;
    @(posedge clk);
    @(negedge clk);
    check("rst_lamps", {lamp_red, lamp_yellow, lamp_green, seq_err}, 6'b100000);
    check("rst_seg_n", seg_n, 7'h7F);
    check("rst_dig_n", dig_n, 2'b10);
    check("rst_disp_valid", disp_valid, 1'b0);
    reset  = 1'b0;
    k      = 0;
    m_prev = OFF;
    m_err  = 1'b0;
    lamp_q.delete();
    lamp_q.push_back(6'b100000);
  endtask

  // After reset with OFF/0 held, the first conversion completes around clock 10-11.
  task automatic warmup();
    for (int i = 1; i <= 14; i++) begin
      disp_chk = (i != 10);
      e_v = (i >= 11);
      e_t = 4'd0;
      e_o = 4'd0;
      tick(OFF, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish by 200000");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    warmup();

    // FORWARD countdown: green down to 4, yellow for 3..1
    disp_chk = 1'b0;
    for (int c = 15; c >= 1; c--) repeat (2) tick(FWD, c);
    // Full legal cycle, then a forced LEFT -> OFF mid-phase
    repeat (3) tick(RIGHT, 12);
    repeat (2) tick(RIGHT, 2);
    repeat (3) tick(LEFT, 9);
    repeat (2) tick(LEFT, 0);
    repeat (2) tick(OFF, 0);
    repeat (2) tick(FWD, 20);
    repeat (2) tick(RIGHT, 20);
    repeat (2) tick(LEFT, 20);
    repeat (3) tick(OFF, 0);

    // Illegal OFF -> RIGHT, sticky through legal phases
    repeat (3) tick(RIGHT, 10);
    repeat (2) tick(LEFT, 10);
    repeat (2) tick(OFF, 0);
    repeat (3) tick(FWD, 10);
    check("seq_err_sticky", seq_err, 1'b1);
    do_reset();
    warmup();

    // 37: old value for 10 clocks, new from clock 11
    disp_chk = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      e_v = 1'b1;
      if (i <= 10) begin e_t = 4'd0; e_o = 4'd0; end
      else         begin e_t = 4'd3; e_o = 4'd7; end
      tick(OFF, 37);
    end

    // 1000 saturates to 99; 5 arrives mid-conversion and follows afterwards
    for (int i = 1; i <= 24; i++) begin
      if (i <= 10)      begin e_t = 4'd3; e_o = 4'd7; end
      else if (i <= 20) begin e_t = 4'd9; e_o = 4'd9; end
      else              begin e_t = 4'd0; e_o = 4'd5; end
      tick(OFF, (i <= 4) ? 32'd1000 : 32'd5);
    end

    // 42 starts a conversion; reset lands while it is shifting
    e_t = 4'd0;
    e_o = 4'd5;
    for (int i = 1; i <= 5; i++) tick(FWD, 42);
    check("pre_rst_disp_valid", disp_valid, 1'b1);
    do_reset();
    warmup();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
